uart_receiver: RTL

UART receiver that consumes the serial line produced by the team's uart_transmitter and recovers each byte. Frame format matches the transmitter exactly:
- 1 start bit (0).
- 8 data bits, Tx_DATA[7] first (MSB-first).
- 1 even-parity bit (0 when the data has an even number of 1s).
- 1 stop bit (1).

Uses 16x oversampling from an internal sample-enable generator driven by baud_select, and delivers the byte with valid/error flags to the host logic.

---
 rtl/uart_receiver.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// UART receiver (start, 8 data bits MSB-first, even parity, stop) using 16x oversampling.
// Optional macro RX_MAJORITY_VOTE_EN: 2-of-3 vote at tick counts 6/7/8 around each bit centre.
module uart_receiver #(
    parameter int CLK_FREQ   = 50000000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [3:0] START_SAMPLE = 4'd8;
    localparam logic [3:0] BIT_SAMPLE   = 4'd8;
    localparam logic [3:0] DATA_LOAD    = 4'd9;
`else
    localparam logic [3:0] START_SAMPLE = 4'd7;
    localparam logic [3:0] BIT_SAMPLE   = 4'd15;
    localparam logic [3:0] DATA_LOAD    = 4'd0;
`endif

    function automatic logic [14:0] divisor(input logic [2:0] sel);
        int baud;
        int div;
        case (sel)
            3'd0:    baud = 32'sd300;
            3'd1:    baud = 32'sd1200;
            3'd2:    baud = 32'sd4800;
            3'd3:    baud = 32'sd9600;
            3'd4:    baud = 32'sd19200;
            3'd5:    baud = 32'sd38400;
            3'd6:    baud = 32'sd57600;
            default: baud = 32'sd115200;
        endcase
        div = (CLK_FREQ + (OVERSAMPLE * baud) / 32'sd2) / (OVERSAMPLE * baud);
        return div[14:0];
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t      state_q;
    logic [3:0]  tick_cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        par_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        perr_q;
    logic        ferr_q;
    logic [1:0]  sync_q;
    logic [14:0] div_cnt_q;
    logic [14:0] div_d;
    logic [2:0]  baud_q;
    logic        tick_s;
    logic        rxs_s;
    logic        bit_s;

    // Two-flop synchroniser, preset to the idle line level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RxD};
        end
    end

    assign rxs_s = sync_q[1];

    // Sample-tick divider next state; a baud change restarts the period without a tick
    always_comb begin
        tick_s = 1'b0;
        div_d  = div_cnt_q;
        if (baud_select != baud_q) begin
            div_d = divisor(baud_select) - 15'd1;
        end else if (div_cnt_q == 15'd0) begin
            div_d  = divisor(baud_select) - 15'd1;
            tick_s = 1'b1;
        end else begin
            div_d = div_cnt_q - 15'd1;
        end
    end

    // Sample-tick divider registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= 15'd0;
            baud_q    <= 3'd0;
        end else begin
            div_cnt_q <= div_d;
            baud_q    <= baud_select;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic vote6_q;
    logic vote7_q;

    // Capture the two early votes; the third is the live sample at the decision tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vote6_q <= 1'b1;
            vote7_q <= 1'b1;
        end else if (tick_s && (tick_cnt_q == 4'd6)) begin
            vote6_q <= rxs_s;
        end else if (tick_s && (tick_cnt_q == 4'd7)) begin
            vote7_q <= rxs_s;
        end
    end

    assign bit_s = maj3(vote6_q, vote7_q, rxs_s);
`else
    assign bit_s = rxs_s;
`endif

    // Frame state machine with registered flags and data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            if (!Rx_EN) begin
                state_q    <= IDLE;
                tick_cnt_q <= 4'd0;
                bit_idx_q  <= 3'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        tick_cnt_q <= 4'd0;
                        bit_idx_q  <= 3'd0;
                        if (!rxs_s) begin
                            state_q <= START;
                        end
                    end
                    START: begin
                        if (tick_s) begin
                            if (tick_cnt_q == START_SAMPLE) begin
                                tick_cnt_q <= DATA_LOAD;
                                state_q    <= bit_s ? IDLE : DATA;
                            end else begin
                                tick_cnt_q <= tick_cnt_q + 4'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (tick_s) begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                            if (tick_cnt_q == BIT_SAMPLE) begin
                                shift_q   <= {shift_q[6:0], bit_s};
                                bit_idx_q <= bit_idx_q + 3'd1;
                                if (bit_idx_q == 3'd7) begin
                                    state_q <= PARITY;
                                end
                            end
                        end
                    end
                    PARITY: begin
                        if (tick_s) begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                            if (tick_cnt_q == BIT_SAMPLE) begin
                                par_q   <= bit_s;
                                state_q <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        if (tick_s) begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                            if (tick_cnt_q == BIT_SAMPLE) begin
                                state_q <= IDLE;
                                if (!bit_s) begin
                                    ferr_q <= 1'b1;
                                end else if (par_q != (^shift_q)) begin
                                    perr_q <= 1'b1;
                                end else begin
                                    data_q  <= shift_q;
                                    valid_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_PERROR = perr_q;
    assign Rx_FERROR = ferr_q;

endmodule
